program_loader: RTL and testbench

Boot-time instruction loader that sits directly upstream of instruction memory and drives its write port. It consumes a byte stream from the UART receiver (length header followed by little-endian instruction words), assembles 32-bit words, and issues one memory write per word at consecutive word addresses. It raises `done` when the programme is fully written; core reset release and fetch start are gated on that signal elsewhere.

---
 rtl/program_loader.sv | 79 +++++++
 tb/tb_program_loader.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: boot-time UART byte stream to instruction-memory writer
//   clk, rst_n (async active-low) | rx_valid, rx_data: incoming bytes, no backpressure
//   we, addr, dout: instruction-memory write port, one pulse per assembled word
//   busy: load in progress | done: all words written | err: header over MAX_WORDS
//   csum: modulo-2^32 sum of all words written
module program_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h0,
  parameter int MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        we,
  output logic [31:0] addr,
  output logic [31:0] dout,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] csum
);
  localparam int IW = $clog2(MAX_WORDS) + 1;
  typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERR} state_t;
  state_t state, state_nx;
  logic [1:0] b;
  logic [23:0] sh;
  logic [31:0] full;
  logic [IW-1:0] nw, i;
  logic take, last;
  // Header and data bytes share one little-endian shifter: after three bytes
  // it holds bits [23:0], and the fourth byte completes the 32-bit value.
  assign full = {rx_data, sh};
  assign take = rx_valid && (state == IDLE || state == LEN || state == DATA);
  assign last = rx_valid && b == 2'd3;
  assign busy = state == LEN || state == DATA;
  assign done = state == DONE;
  assign err = state == ERR;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = rx_valid ? LEN : IDLE;
      LEN:  state_nx = !last ? LEN : full == 32'd0 ? DONE : full > 32'(MAX_WORDS) ? ERR : DATA;
      DATA: state_nx = last && i + 1'b1 == nw ? DONE : DATA;
      default: state_nx = state;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b <= 2'd0;
      sh <= 24'd0;
      nw <= '0;
      i <= '0;
      we <= 1'b0;
      addr <= ADDR_BASE;
      dout <= 32'd0;
      csum <= 32'd0;
    end else begin
      we <= 1'b0;
      if (we) csum <= csum + dout;
      if (take) begin
        sh <= {rx_data, sh[23:8]};
        b <= b + 2'd1;
        if (state == LEN && last) begin
          nw <= full[IW-1:0];
          i <= '0;
        end
        if (state == DATA && last) begin
          we <= 1'b1;
          addr <= ADDR_BASE + (32'(i) << 2);
          dout <= full;
          i <= i + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed table-driven checks of program_loader
module tb_program_loader;
  typedef struct {logic [31:0] a, d; int c; logic dn;} wr_t;
  typedef struct {logic [31:0] word, a;} vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic rv0 = 1'b0, rv1 = 1'b0;
  logic [7:0] rd0 = 8'd0, rd1 = 8'd0;
  logic we0, we1, busy0, busy1, done0, done1, err0, err1;
  logic [31:0] addr0, addr1, dout0, dout1, csum0, csum1;
  logic pd0 = 1'b0, pe1 = 1'b0;
  int cyc = 0, dr0 = -1, er1 = -1, errors = 0, checks = 0;
  int vc0[$], vc1[$];
  wr_t w0[$], w1[$];
  logic [7:0] bq[$];
  vec_t tv[5];
  always #5 clk = ~clk;
  program_loader dut0 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rv0), .rx_data(rd0), .we(we0), .addr(addr0),
    .dout(dout0), .busy(busy0), .done(done0), .err(err0), .csum(csum0)
  );
  program_loader #(.ADDR_BASE(32'h1000), .MAX_WORDS(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rv1), .rx_data(rd1), .we(we1), .addr(addr1),
    .dout(dout1), .busy(busy1), .done(done1), .err(err1), .csum(csum1)
  );
  always @(negedge clk) begin
    cyc++;
    if (rv0) vc0.push_back(cyc);
    if (rv1) vc1.push_back(cyc);
    if (we0) w0.push_back('{addr0, dout0, cyc, done0});
    if (we1) w1.push_back('{addr1, dout1, cyc, done1});
    if (done0 && !pd0) dr0 = cyc;
    if (err1 && !pe1) er1 = cyc;
    pd0 = done0;
    pe1 = err1;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic clr;
    vc0.delete(); vc1.delete(); w0.delete(); w1.delete();
    dr0 = -1; er1 = -1;
  endtask
  task automatic do_reset;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    clr();
  endtask
  task automatic send(input bit s, input int gap);
    foreach (bq[k]) begin
      @(posedge clk); #1;
      if (s) begin rv1 = 1'b1; rd1 = bq[k]; end
      else begin rv0 = 1'b1; rd0 = bq[k]; end
      if (gap > 0) begin
        @(posedge clk); #1; rv0 = 1'b0; rv1 = 1'b0;
        repeat (gap - 1) @(posedge clk);
      end
    end
    @(posedge clk); #1; rv0 = 1'b0; rv1 = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    tv[0] = '{32'h00000013, 32'd0};
    tv[1] = '{32'hdeadbeef, 32'd4};
    tv[2] = '{32'h12345678, 32'd8};
    tv[3] = '{32'hffffffff, 32'd12};
    tv[4] = '{32'h80000001, 32'd16};
    repeat (2) @(negedge clk);
    chk("rst we", {31'd0, we0}, 32'd0);
    chk("rst addr", addr0, 32'd0);
    chk("rst dout", dout0, 32'd0);
    chk("rst busy", {31'd0, busy0}, 32'd0);
    chk("rst done", {31'd0, done0}, 32'd0);
    chk("rst err", {31'd0, err0}, 32'd0);
    chk("rst csum", csum0, 32'd0);
    chk("rst addr base", addr1, 32'h1000);
    @(negedge clk); rst_n = 1'b1;
    clr();
    // basic two-word load, spaced bytes
    bq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h80, 8'h3e, 8'h13, 8'h01, 8'h00, 8'h83};
    send(1'b0, 3);
    chk("basic count", 32'(w0.size()), 32'd2);
    if (w0.size() == 2) begin
      chk("basic a0", w0[0].a, 32'd0);
      chk("basic d0", w0[0].d, 32'h3e800093);
      chk("basic a1", w0[1].a, 32'd4);
      chk("basic d1", w0[1].d, 32'h83000113);
      chk("basic lat", 32'(w0[1].c - vc0[11]), 32'd1);
      chk("basic done cyc", 32'(dr0), 32'(w0[1].c));
    end
    chk("basic done", {31'd0, done0}, 32'd1);
    chk("basic busy", {31'd0, busy0}, 32'd0);
    chk("basic csum", csum0, 32'hc18001a6);
    chk("basic addr hold", addr0, 32'd4);
    // back-to-back, table driven
    do_reset();
    bq = '{8'h05, 8'h00, 8'h00, 8'h00};
    foreach (tv[j]) for (int k = 0; k < 4; k++) bq.push_back(tv[j].word[8*k +: 8]);
    send(1'b0, 0);
    chk("b2b count", 32'(w0.size()), 32'd5);
    for (int j = 0; j < 5 && j < w0.size(); j++) begin
      chk($sformatf("b2b a%0d", j), w0[j].a, tv[j].a);
      chk($sformatf("b2b d%0d", j), w0[j].d, tv[j].word);
      chk($sformatf("b2b lat%0d", j), 32'(w0[j].c - vc0[7 + 4 * j]), 32'd1);
      chk($sformatf("b2b done%0d", j), {31'd0, w0[j].dn}, {31'd0, j == 4});
    end
    chk("b2b csum", csum0, 32'h70e2157a);
    // zero length
    do_reset();
    bq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send(1'b0, 0);
    chk("zero done cyc", 32'(dr0 - vc0[3]), 32'd1);
    chk("zero we", 32'(w0.size()), 32'd0);
    chk("zero csum", csum0, 32'd0);
    chk("zero done", {31'd0, done0}, 32'd1);
    // oversize header on MAX_WORDS=4 instance
    bq = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send(1'b1, 0);
    chk("ovr err cyc", 32'(er1 - vc1[3]), 32'd1);
    chk("ovr err", {31'd0, err1}, 32'd1);
    chk("ovr busy", {31'd0, busy1}, 32'd0);
    chk("ovr done", {31'd0, done1}, 32'd0);
    chk("ovr we", 32'(w1.size()), 32'd0);
    // exactly MAX_WORDS is accepted
    do_reset();
    bq = '{8'h04, 8'h00, 8'h00, 8'h00};
    send(1'b1, 0);
    chk("max busy", {31'd0, busy1}, 32'd1);
    chk("max err", {31'd0, err1}, 32'd0);
    // reset mid-load
    do_reset();
    bq = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send(1'b0, 1);
    chk("mid count", 32'(w0.size()), 32'd1);
    chk("mid busy", {31'd0, busy0}, 32'd1);
    @(negedge clk); #2; rst_n = 1'b0; #1;
    chk("mid rst we", {31'd0, we0}, 32'd0);
    chk("mid rst busy", {31'd0, busy0}, 32'd0);
    chk("mid rst dout", dout0, 32'd0);
    chk("mid rst csum", csum0, 32'd0);
    chk("mid rst addr", addr0, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    clr();
    bq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hb3, 8'h01, 8'h10, 8'h00};
    send(1'b0, 2);
    chk("mid2 count", 32'(w0.size()), 32'd1);
    if (w0.size() == 1) begin
      chk("mid2 a", w0[0].a, 32'd0);
      chk("mid2 d", w0[0].d, 32'h001001b3);
    end
    chk("mid2 csum", csum0, 32'h001001b3);
    chk("mid2 done", {31'd0, done0}, 32'd1);
    // non-zero base, bytes after done ignored
    do_reset();
    bq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0a, 8'h0b, 8'h0c, 8'h0d,
           8'hff, 8'hff, 8'hff, 8'hff};
    send(1'b1, 0);
    chk("base count", 32'(w1.size()), 32'd2);
    if (w1.size() == 2) begin
      chk("base a0", w1[0].a, 32'h1000);
      chk("base d0", w1[0].d, 32'h04030201);
      chk("base a1", w1[1].a, 32'h1004);
      chk("base d1", w1[1].d, 32'h0d0c0b0a);
    end
    chk("base csum", csum1, 32'h110f0d0b);
    chk("base done", {31'd0, done1}, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
